cbadder32: RTL and testbench

CBADDER32 -- requirements
Module: cbadder32

---
 rtl/cbadder32.sv | 83 ++++++++
 tb/tb_cbadder32.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/cbadder32.sv
// 32-bit carry-skip adder with combinational and once-registered outputs.
// Define CBADDER32_SKIP_EN to add the block bypass muxes; otherwise it is a plain ripple-carry adder.
module cbadder32 #(
  parameter int BLOCK_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic [31:0] sum_q,
  output logic        cout_q,
  output logic        ovf_q
);

  localparam int NBLK = 32 / BLOCK_W;

  genvar gi;
  generate
    for (gi = 0; gi < NBLK; gi++) begin : g_blk
      logic               blk_cin;
      logic               blk_cout;
      logic               ripple_cout;
      logic [BLOCK_W-1:0] blk_sum;
`ifdef CBADDER32_SKIP_EN
      logic               blk_p;
`endif

      // Each block gets its own carry signals so the chain is not a self-referencing vector.
      if (gi == 0) begin : g_first
        assign blk_cin = cin;
      end else begin : g_rest
        assign blk_cin = g_blk[gi-1].blk_cout;
      end

      always_comb begin
        logic c;
        blk_sum = '0;
        c       = blk_cin;
`ifdef CBADDER32_SKIP_EN
        blk_p   = 1'b1;
`endif
        for (int i = 0; i < BLOCK_W; i++) begin
          blk_sum[i] = a[gi*BLOCK_W+i] ^ b[gi*BLOCK_W+i] ^ c;
`ifdef CBADDER32_SKIP_EN
          blk_p      = blk_p & (a[gi*BLOCK_W+i] ^ b[gi*BLOCK_W+i]);
`endif
          c          = (a[gi*BLOCK_W+i] & b[gi*BLOCK_W+i]) |
                       (c & (a[gi*BLOCK_W+i] ^ b[gi*BLOCK_W+i]));
        end
        ripple_cout = c;
      end

`ifdef CBADDER32_SKIP_EN
      assign blk_cout = blk_p ? blk_cin : ripple_cout;
`else
      assign blk_cout = ripple_cout;
`endif

      assign sum[gi*BLOCK_W +: BLOCK_W] = blk_sum;
    end
  endgenerate

  assign cout = g_blk[NBLK-1].blk_cout;
  // Carry into bit 31 is recovered from the sum bit itself: a^b^c31 = sum[31].
  assign ovf  = a[31] ^ b[31] ^ sum[31] ^ cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_cbadder32.sv
// Scoreboard bench for cbadder32: driver pushes expected results, monitor checks after each edge.
module tb_cbadder32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic [31:0] sum, sum_q;
  logic        cout, ovf, cout_q, ovf_q;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t q[$];

  cbadder32 #(.BLOCK_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .ovf(ovf),
    .sum_q(sum_q), .cout_q(cout_q), .ovf_q(ovf_q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit addition; overflow from the signed rule (same-sign operands, different-sign result).
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic c);
    exp_t e;
    logic [32:0] full;
    full  = {1'b0, x} + {1'b0, y} + {32'd0, c};
    e.a   = x;
    e.b   = y;
    e.cin = c;
    e.s   = full[31:0];
    e.co  = full[32];
    e.ov  = (x[31] == y[31]) && (full[31] != x[31]);
    return e;
  endfunction

  task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic c);
    @(negedge clk);
    a   = x;
    b   = y;
    cin = c;
    q.push_back(model(x, y, c));
  endtask

  // Monitor: each edge registers the vector driven on the preceding falling edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sum",    sum,           e.s);
        chk("cout",   {31'd0, cout}, {31'd0, e.co});
        chk("ovf",    {31'd0, ovf},  {31'd0, e.ov});
        chk("sum_q",  sum_q,         e.s);
        chk("cout_q", {31'd0, cout_q}, {31'd0, e.co});
        chk("ovf_q",  {31'd0, ovf_q},  {31'd0, e.ov});
        $display("[TB] a=%h b=%h cin=%0d sum=%h cout=%0d ovf=%0d", e.a, e.b, e.cin, sum, cout, ovf);
      end
    end
  end

  initial begin
    logic [31:0] r;
    int          waited;

    #1 rst_n = 1'b0;
    #2;
    chk("rst sum_q",  sum_q,           32'd0);
    chk("rst cout_q", {31'd0, cout_q}, 32'd0);
    chk("rst ovf_q",  {31'd0, ovf_q},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int x = -4; x <= 4; x++)
      for (int y = -4; y <= 4; y++)
        for (int c = 0; c <= 1; c++)
          issue(32'(x), 32'(y), c[0]);

    issue(32'h0000000F, 32'hFFFFFFF0, 1'b1);
    issue(32'h7FFFFFFF, 32'd1, 1'b0);
    issue(32'h80000000, 32'h80000000, 1'b0);
    issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    issue(32'h00000000, 32'h00000000, 1'b0);
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      issue(r, ~r, i[0]);
    end
    for (int i = 0; i < 2000; i++)
      issue($urandom, $urandom, 1'($urandom_range(0, 1)));

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    chk("scoreboard drained", 32'(q.size()), 32'd0);

    // Directed: zero-latency sum, one-cycle register, async reset mid-cycle, clean restart.
    @(negedge clk);
    a = 32'd5; b = 32'd3; cin = 1'b0;
    #1;
    chk("comb 5+3", sum, 32'd8);
    @(posedge clk);
    #1;
    chk("reg 5+3", sum_q, 32'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst sum_q", sum_q, 32'd0);
    chk("rst keeps sum", sum, 32'd8);
    @(negedge clk);
    rst_n = 1'b1;
    a = 32'd100; b = 32'd23;
    @(posedge clk);
    #1;
    chk("first capture after rst", sum_q, 32'd123);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
